status_gen: RTL

Flag-producing end of the datapath's status interface: computes the {Z, N, V} condition flags from an ALU operation and delivers them, registered, to the branch-condition evaluator. It sits between the register-file read stage and the branch unit. It is a two-stage pipeline: an operand register, then a flag/result register. A valid/ready handshake on the input and a valid/ack handshake on the output keep a flag set from being overwritten before the branch unit has consumed it.

---
 rtl/status_gen.sv | 92 +++++++++
 1 files changed

// File: rtl/status_gen.sv
// Two-stage ALU flag generator: operand register, then a {Z,N,V}/result register
// handed to the branch unit over a valid/ack handshake.
module status_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [1:0]       aluop,
    output logic [2:0]       status,
    output logic [WIDTH-1:0] result,
    output logic             status_valid,
    input  logic             status_ack
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam int         MSB     = WIDTH - 1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;
    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] alu_r;
    logic             alu_v;

    // Stage 2 can take a new set when it is empty or its current set is being acked.
    assign adv      = s1_valid & (~status_valid | status_ack);
    assign in_ready = ~s1_valid | adv;
    assign accept   = in_valid & in_ready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        alu_r = '0;
        alu_v = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_r = s1_a + s1_b;
                alu_v = (s1_a[MSB] == s1_b[MSB]) & (alu_r[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                alu_r = s1_a - s1_b;
                alu_v = (s1_a[MSB] != s1_b[MSB]) & (alu_r[MSB] != s1_a[MSB]);
            end
            OP_AND:  alu_r = s1_a & s1_b;
            default: alu_r = ~s1_b;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= ain;
                s1_b     <= bin;
                s1_op    <= aluop;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // An ack coinciding with an advance is absorbed by the reload, so valid never bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status       <= 3'b000;
            result       <= '0;
            status_valid <= 1'b0;
        end else begin
            if (adv) begin
                result       <= alu_r;
                status       <= {(alu_r == '0), alu_r[MSB], alu_v};
                status_valid <= 1'b1;
            end else if (status_ack) begin
                status_valid <= 1'b0;
            end
        end
    end

endmodule
